lsu_mem_stage: RTL

- Memory-access stage directly downstream of the ALU; consumes the ALU-computed effective address plus the 5-bit ALU select code for load/store ops (lb=21, lbu=22, lh=23, lhu=24, lw=25, sb=26, sh=27, sw=28).
- Drives a single-outstanding data-memory request/grant/rvalid bus with byte enables and lane-shifted store data.
- Returns sign- or zero-extended load data to writeback through a valid/ready handshake.
- Flags misaligned accesses without touching memory.

---
 rtl/lsu_mem_stage.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : Load/store memory stage. Single-outstanding req/gnt/rvalid data
//            bus, lane-aligned stores, sign/zero-extended loads, misalign
//            detection. Optional response watchdog: define LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module lsu_mem_stage #(
    parameter int ADDR_W      = 32,
    parameter int RD_W        = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [31:0]       wb_data_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [4:0] c_OP_LB  = 5'd21;
    localparam logic [4:0] c_OP_LBU = 5'd22;
    localparam logic [4:0] c_OP_LH  = 5'd23;
    localparam logic [4:0] c_OP_LHU = 5'd24;
    localparam logic [4:0] c_OP_SB  = 5'd26;
    localparam logic [4:0] c_OP_SH  = 5'd27;
    localparam logic [4:0] c_OP_SW  = 5'd28;

    localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;

    logic [1:0]        r_state;
    logic              r_ready;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_lbyte;
    logic              r_lhalf;
    logic              r_sext;
    logic [1:0]        r_boff;
    logic [RD_W-1:0]   r_rd;
    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_is_mem;
    logic              w_is_store;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_misal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_rbyte;
    logic [15:0]       w_rhalf;
    logic [31:0]       w_ldata;
    logic              w_tmo;

    always_comb begin
        w_is_mem   = (op_i >= c_OP_LB) && (op_i <= c_OP_SW);
        w_is_store = (op_i >= c_OP_SB) && (op_i <= c_OP_SW);
        w_is_byte  = (op_i == c_OP_LB) || (op_i == c_OP_LBU) || (op_i == c_OP_SB);
        w_is_half  = (op_i == c_OP_LH) || (op_i == c_OP_LHU) || (op_i == c_OP_SH);
        w_misal    = (w_is_half && addr_i[0]) ||
                     (!w_is_byte && !w_is_half && (addr_i[1:0] != 2'b00));
        if (w_is_byte) begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wdata_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << addr_i[1:0];
            w_wdata = {2{wdata_i[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = wdata_i;
        end
        // Loads share the store byte mask but never drive write data.
        if (!w_is_store) begin
            w_wdata = 32'd0;
        end
    end

    always_comb begin
        case (r_boff)
            2'd0:    w_rbyte = mem_rdata_i[7:0];
            2'd1:    w_rbyte = mem_rdata_i[15:8];
            2'd2:    w_rbyte = mem_rdata_i[23:16];
            default: w_rbyte = mem_rdata_i[31:24];
        endcase
        w_rhalf = r_boff[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        if (r_lbyte) begin
            w_ldata = {{24{r_sext & w_rbyte[7]}}, w_rbyte};
        end else if (r_lhalf) begin
            w_ldata = {{16{r_sext & w_rhalf[15]}}, w_rhalf};
        end else begin
            w_ldata = mem_rdata_i;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_TCNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [c_TCNT_W-1:0] c_TLAST = c_TCNT_W'(TIMEOUT_CYC - 1);

    logic [c_TCNT_W-1:0] r_tcnt;

    // Cleared while idle (entry to REQ) and on grant (entry to WAIT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if ((r_state == S_IDLE) || ((r_state == S_REQ) && mem_gnt_i)) begin
            r_tcnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_tmo = ((r_state == S_REQ) || (r_state == S_WAIT)) && (r_tcnt == c_TLAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_lbyte    <= 1'b0;
            r_lhalf    <= 1'b0;
            r_sext     <= 1'b0;
            r_boff     <= 2'd0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i && w_is_mem) begin
                        if (w_misal) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_MISALIGN;
                        end else begin
                            r_state <= S_REQ;
                            r_ready <= 1'b0;
                            r_req   <= 1'b1;
                            r_we    <= w_is_store;
                            r_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_lbyte <= w_is_byte;
                            r_lhalf <= w_is_half;
                            r_sext  <= (op_i == c_OP_LB) || (op_i == c_OP_LH);
                            r_boff  <= addr_i[1:0];
                            r_rd    <= rd_i;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i || w_tmo) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_be    <= 4'd0;
                        r_wdata <= 32'd0;
                        if (mem_gnt_i && !r_we) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                        if (!mem_gnt_i) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_TIMEOUT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_wb_data  <= w_ldata;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_ready    <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TIMEOUT;
                    end
                end
                S_RESP: begin
                    if (wb_ready_i) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
    assign wb_valid_o  = r_wb_valid;
    assign wb_data_o   = r_wb_data;
    assign wb_rd_o     = r_rd;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;

endmodule
`default_nettype wire
